// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: stopwatch controller signal bundle.
//   btn_start_stop, btn_lap, btn_clear : raw active-high pushbuttons (master -> slave)
//   tick                               : one-cycle tenths enable (slave -> master)
//   cnt_clear                          : one-cycle digit-counter clear (slave -> master)
//   freeze                             : display hold level, high in LAP (slave -> master)
//   state                              : FSM state IDLE=00 RUN=01 PAUSED=10 LAP=11 (slave -> master)
interface stopwatch_ctrl_if;
    logic       btn_start_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic       tick;
    logic       cnt_clear;
    logic       freeze;
    logic [1:0] state;
    modport master (
        output btn_start_stop, btn_lap, btn_clear,
        input  tick, cnt_clear, freeze, state
    );
    modport slave (
        input  btn_start_stop, btn_lap, btn_clear,
        output tick, cnt_clear, freeze, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, run/pause/lap FSM and tenth-second prescaler.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : stopwatch_ctrl_if.slave (buttons in; tick, cnt_clear, freeze, state out)
//   Macro STOPWATCH_DEBOUNCE_EN: defined -> DEBOUNCE_CYCLES-sample debounce filter per button;
//   undefined -> events taken straight from the synchronized levels.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 10000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, LAP = 2'b11} state_t;

    if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("stopwatch_ctrl: TICK_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    state_t        cur, nxt;
    logic [2:0]    raw, s1, s2, lvl, armed, ev;
    logic [1:0]    warm;
    logic [PW-1:0] presc;
    logic          go_ss, go_lap, go_clr, clr_hit, running, cnt_clear_q, freeze_q;

    // bit 0 start_stop, bit 1 lap, bit 2 clear
    assign raw = {bus.btn_clear, bus.btn_lap, bus.btn_start_stop};

    // warm marks s2 as holding real samples; a button only arms once it is
    // seen released, so one held through reset yields no event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= '0;
            s2    <= '0;
            warm  <= '0;
            armed <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            warm  <= {warm[0], 1'b1};
            armed <= armed | ({3{warm[1]}} & ~s2);
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          lvl_q, ev_q;
        // counts consecutive samples that disagree with the accepted level
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt   <= '0;
                lvl_q <= 1'b0;
                ev_q  <= 1'b0;
            end else begin
                ev_q <= 1'b0;
                if (s2[i] == lvl_q) begin
                    cnt <= '0;
                end else if (cnt == D_MAX) begin
                    cnt   <= '0;
                    lvl_q <= s2[i];
                    ev_q  <= s2[i] & armed[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
        assign lvl[i] = lvl_q;
        assign ev[i]  = ev_q;
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl <= '0;
            ev  <= '0;
        end else begin
            lvl <= s2;
            ev  <= s2 & ~lvl & armed;
        end
    end
`endif

    // clear > start_stop > lap; losers in the same cycle are dropped
    assign go_clr  = ev[2];
    assign go_ss   = ev[0] & ~ev[2];
    assign go_lap  = ev[1] & ~ev[0] & ~ev[2];
    assign running = (cur == RUN) || (cur == LAP);

    always_comb begin
        nxt     = cur;
        clr_hit = 1'b0;
        unique case (cur)
            IDLE: begin
                if (go_ss) nxt = RUN;
                else if (go_clr) clr_hit = 1'b1;
            end
            RUN: begin
                if (go_ss) nxt = PAUSED;
                else if (go_lap) nxt = LAP;
            end
            LAP: begin
                if (go_lap) nxt = RUN;
                else if (go_ss) nxt = PAUSED;
            end
            PAUSED: begin
                if (go_ss) nxt = RUN;
                else if (go_clr) begin
                    nxt     = IDLE;
                    clr_hit = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= IDLE;
            cnt_clear_q <= 1'b0;
            freeze_q    <= 1'b0;
            presc       <= '0;
        end else begin
            cur         <= nxt;
            cnt_clear_q <= clr_hit;
            freeze_q    <= (nxt == LAP);
            presc       <= (nxt == IDLE) ? '0 : running ? ((presc == P_MAX) ? '0 : presc + 1'b1) : presc;
        end
    end

    assign bus.tick      = running & (presc == P_MAX);
    assign bus.cnt_clear = cnt_clear_q;
    assign bus.freeze    = freeze_q;
    assign bus.state     = cur;
endmodule
